// File: rtl/can_pkg.sv
// can_pkg: shared states, field lengths and buffer layout for the CAN frame generator
package can_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC,
    S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF, S_IFS
  } state_t;
  localparam logic [14:0] CRC15_POLY = 15'h4599;
  localparam int ID_LEN = 11;
  localparam int DLC_LEN = 4;
  localparam int CRC_LEN = 15;
  localparam int EOF_LEN = 7;
  localparam int IFS_LEN = 3;
  localparam int STUFF_LIM = 5;
  localparam int B_ID_HI = 0;
  localparam int B_CTRL = 1;
  localparam int B_DATA0 = 2;
endpackage

// File: rtl/can_crc15.sv
// can_crc15: bit-serial CAN CRC-15 accumulator
module can_crc15
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        g_rst,
  input  logic        clear,
  input  logic        enable,
  input  logic        crc_bit,
  output logic [14:0] crc
);
  // Shift one unstuffed frame bit into the CRC register
  always_ff @(posedge clk or negedge g_rst)
    if (!g_rst) crc <= '0;
    else if (clear) crc <= '0;
    else if (enable) crc <= {crc[13:0], 1'b0} ^ ((crc_bit ^ crc[14]) ? CRC15_POLY : 15'd0);
endmodule

// File: rtl/can_frame_gen.sv
// can_frame_gen: serializes a CAN 2.0A buffer into a stuffed frame (CAN_ARB_MONITOR_EN adds arbitration loss detection)
module can_frame_gen
  import can_pkg::*;
#(
  parameter int MAX_DATA_BYTES = 8
) (
  input  logic        clk,
  input  logic        g_rst,
  input  logic        bit_tick,
  input  logic        frame_gen_intl,
  input  logic [79:0] tx_frame,
  input  logic        rx_bit,
  output logic        tx_bit,
  output logic        tx_active,
  output logic        tx_success,
  output logic        ack_err,
  output logic        arb_lost
);
  localparam logic [3:0] MAXB = 4'(MAX_DATA_BYTES);
  state_t state, a_state, n_state;
  logic [6:0] cnt, a_cnt, n_cnt, dlast;
  logic [79:0] sh;
  logic [7:0] ctl;
  logic [63:0] dat;
  logic [11:0] arb_v;
  logic [5:0] ctrl_v;
  logic [3:0] nby;
  logic [14:0] crc;
  logic [2:0] run;
  logic armed, latch, go, stuff, nack, lost, abort, fbit, n_bit, crc_en;
  assign ctl = sh[8*B_CTRL +: 8];
  assign dat = sh[8*B_DATA0 +: 64];
  assign arb_v = {sh[8*B_ID_HI +: 8], ctl[7:4]};
  assign ctrl_v = {2'b00, ctl[3:0]};
  assign nby = ctl[4] ? 4'd0 : (ctl[3:0] > MAXB ? MAXB : ctl[3:0]);
  assign dlast = {nby, 3'b000} - 7'd1;
  assign latch = (state == S_IDLE) && !armed && frame_gen_intl;
  assign go = bit_tick && (state != S_IDLE || armed);
  assign stuff = (state inside {S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC}) && (run == 3'(STUFF_LIM));
  assign nack = (state == S_ACK_SLOT) && rx_bit;
  assign abort = nack || lost;
  assign tx_active = state != S_IDLE;
  assign crc_en = go && !stuff && !abort && (a_state inside {S_SOF, S_ARB, S_CTRL, S_DATA});
`ifdef CAN_ARB_MONITOR_EN
  assign lost = (state == S_ARB) && tx_bit && !rx_bit;
  // Report a recessive bit overwritten by a dominant one during arbitration
  always_ff @(posedge clk or negedge g_rst)
    if (!g_rst) arb_lost <= 1'b0;
    else arb_lost <= go && lost;
`else
  assign lost = 1'b0;
  assign arb_lost = 1'b0;
`endif
  can_crc15 u_crc (
    .clk(clk),
    .g_rst(g_rst),
    .clear(latch),
    .enable(crc_en),
    .crc_bit(fbit),
    .crc(crc)
  );
  // Field position that follows the current (non-stuff) bit
  always_comb begin
    a_state = state;
    a_cnt = cnt + 7'd1;
    case (state)
      S_IDLE:     begin a_state = S_SOF; a_cnt = '0; end
      S_SOF:      begin a_state = S_ARB; a_cnt = '0; end
      S_ARB:      if (cnt == 7'(ID_LEN)) begin a_state = S_CTRL; a_cnt = '0; end
      S_CTRL:     if (cnt == 7'(DLC_LEN + 1)) begin a_state = (nby == 4'd0) ? S_CRC : S_DATA; a_cnt = '0; end
      S_DATA:     if (cnt == dlast) begin a_state = S_CRC; a_cnt = '0; end
      S_CRC:      if (cnt == 7'(CRC_LEN - 1)) begin a_state = S_CRC_DEL; a_cnt = '0; end
      S_CRC_DEL:  begin a_state = S_ACK_SLOT; a_cnt = '0; end
      S_ACK_SLOT: begin a_state = S_ACK_DEL; a_cnt = '0; end
      S_ACK_DEL:  begin a_state = S_EOF; a_cnt = '0; end
      S_EOF:      if (cnt == 7'(EOF_LEN - 1)) begin a_state = S_IFS; a_cnt = '0; end
      S_IFS:      if (cnt == 7'(IFS_LEN - 1)) begin a_state = S_IDLE; a_cnt = '0; end
      default:    begin a_state = S_IDLE; a_cnt = '0; end
    endcase
  end
  assign fbit = (a_state == S_SOF)  ? 1'b0 :
                (a_state == S_ARB)  ? arb_v[4'(ID_LEN) - a_cnt[3:0]] :
                (a_state == S_CTRL) ? ctrl_v[3'(DLC_LEN + 1) - a_cnt[2:0]] :
                (a_state == S_DATA) ? dat[{a_cnt[5:3], ~a_cnt[2:0]}] :
                (a_state == S_CRC)  ? crc[4'(CRC_LEN - 1) - a_cnt[3:0]] : 1'b1;
  // At each bit boundary: abort, insert a stuff bit, or move to the next field bit
  always_comb begin
    n_state = !go ? state : abort ? S_IDLE : stuff ? state : a_state;
    n_cnt = !go ? cnt : abort ? 7'd0 : stuff ? cnt : a_cnt;
    n_bit = !go ? tx_bit : abort ? 1'b1 : stuff ? ~tx_bit : fbit;
  end
  // Frame state, bus drive, stuffing run length, shadow buffer and status pulses
  always_ff @(posedge clk or negedge g_rst)
    if (!g_rst) begin
      state <= S_IDLE;
      cnt <= '0;
      tx_bit <= 1'b1;
      run <= '0;
      armed <= 1'b0;
      sh <= '0;
      tx_success <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      state <= n_state;
      cnt <= n_cnt;
      tx_bit <= n_bit;
      run <= go ? ((n_bit == tx_bit) ? run + 3'd1 : 3'd1) : run;
      armed <= latch || (armed && !go);
      sh <= latch ? tx_frame : sh;
      tx_success <= go && (state == S_EOF) && (cnt == 7'(EOF_LEN - 1));
      ack_err <= go && nack;
    end
endmodule

// File: tb/tb_can_frame_gen.sv
// tb_can_frame_gen: directed frames checked against hand values and a reference frame builder
module tb_can_frame_gen;
  logic clk, g_rst, bit_tick, frame_gen_intl, rx_bit;
  logic tx_bit, tx_active, tx_success, ack_err, arb_lost;
  logic [79:0] tx_frame;
  int n_tests, n_fail;
  logic cap [0:255];
  logic ex [0:255];
  int fpos, last_len, succ_cnt, ack_cnt, arb_cnt, nex, nreg, ack_pos, arb_pos, div;
  logic ack_val, arb_en, tick_en;

  can_frame_gen dut (
    .clk(clk),
    .g_rst(g_rst),
    .bit_tick(bit_tick),
    .frame_gen_intl(frame_gen_intl),
    .tx_frame(tx_frame),
    .rx_bit(rx_bit),
    .tx_bit(tx_bit),
    .tx_active(tx_active),
    .tx_success(tx_success),
    .ack_err(ack_err),
    .arb_lost(arb_lost)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    bit_tick = 0;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      div = (div + 1) % 4;
      bit_tick = tick_en && div == 0;
    end
  end

  initial begin
    rx_bit = 1;
    fpos = 0;
    last_len = 0;
    succ_cnt = 0;
    ack_cnt = 0;
    arb_cnt = 0;
    forever begin
      @(negedge clk);
      if (!tx_active) fpos = 0;
      rx_bit = (tx_active && arb_en && fpos == arb_pos) ? 1'b0 :
               (tx_active && fpos == ack_pos) ? ack_val : tx_bit;
      if (bit_tick && tx_active) begin
        cap[fpos] = tx_bit;
        fpos++;
        last_len = fpos;
      end
      if (tx_success) succ_cnt++;
      if (ack_err) ack_cnt++;
      if (arb_lost) arb_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build(input logic [79:0] f);
    logic ub[$];
    logic [10:0] id;
    logic [3:0] dlc;
    logic [14:0] c;
    logic b, last;
    int n, r;
    id = {f[7:0], f[15:13]};
    dlc = f[11:8];
    n = f[12] ? 0 : (dlc > 8 ? 8 : int'(dlc));
    ub = {};
    ub.push_back(1'b0);
    for (int i = 10; i >= 0; i--) ub.push_back(id[i]);
    ub.push_back(f[12]);
    ub.push_back(1'b0);
    ub.push_back(1'b0);
    for (int i = 3; i >= 0; i--) ub.push_back(dlc[i]);
    for (int j = 0; j < n; j++)
      for (int i = 7; i >= 0; i--) ub.push_back(f[16 + 8*j + i]);
    c = 0;
    foreach (ub[k]) begin
      b = ub[k] ^ c[14];
      c = {c[13:0], 1'b0} ^ (b ? 15'h4599 : 15'h0);
    end
    for (int i = 14; i >= 0; i--) ub.push_back(c[i]);
    nex = 0;
    r = 0;
    last = 1;
    foreach (ub[k]) begin
      ex[nex++] = ub[k];
      r = (ub[k] == last) ? r + 1 : 1;
      last = ub[k];
      if (r == 5) begin
        ex[nex++] = ~last;
        last = ~last;
        r = 1;
      end
    end
    nreg = nex;
    repeat (13) ex[nex++] = 1'b1;
  endtask

  task automatic cmp_stream(input string tag);
    int nb;
    nb = 0;
    for (int i = 0; i < nex; i++) if (cap[i] !== ex[i]) nb++;
    chk(tag, nb, 0);
  endtask

  task automatic send(input logic [79:0] f, input string tag);
    int to_a, to_b;
    tx_frame = f;
    frame_gen_intl = 1;
    to_a = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_active) tx_frame = ~f;
      if (tx_success || ack_err || arb_lost) begin
        to_a = 0;
        break;
      end
    end
    frame_gen_intl = 0;
    to_b = 1;
    for (int i = 0; i < 100; i++) begin
      if (!tx_active) begin
        to_b = 0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    chk({tag, "_timeout"}, to_a + to_b, 0);
  endtask

  initial begin
    logic [79:0] f2, f3, f5, f6;
    logic [19:0] h;
    int s0, a0, r0, to, bad;
    n_tests = 0;
    n_fail = 0;
    tick_en = 1;
    g_rst = 0;
    frame_gen_intl = 0;
    tx_frame = 0;
    ack_pos = 999;
    ack_val = 0;
    arb_en = 0;
    arb_pos = 0;
    f2 = {56'h0, 8'hAA, 8'h61, 8'h24};
    f3 = 80'h0;
    f5 = {64'h0, 8'hE0, 8'hFF};
    f6 = {64'hFF00_0F1E_2D3C_4B5A, 8'hAF, 8'hAA};

    repeat (3) @(negedge clk);
    chk("rst_tx_bit", tx_bit, 1);
    chk("rst_active", tx_active, 0);
    chk("rst_pulses", {tx_success, ack_err, arb_lost}, 0);
    g_rst = 1;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (tx_active || !tx_bit) bad = 1;
    end
    chk("idle_20ticks", bad, 0);

    build(f2);
    ack_pos = nreg + 1;
    tick_en = 0;
    tx_frame = f2;
    frame_gen_intl = 1;
    repeat (20) @(negedge clk);
    chk("no_tick_hold", {tx_active, tx_bit}, 2'b01);
    tick_en = 1;
    s0 = succ_cnt;
    send(f2, "t2");
    for (int i = 0; i < 20; i++) h[19-i] = cap[i];
    chk("t2_head", h, 20'h12305);
    chk("t2_success", succ_cnt - s0, 1);
    chk("t2_len", last_len, nex);
    cmp_stream("t2_stream");
    chk("t2_idle", {tx_active, tx_bit}, 2'b01);

    build(f3);
    ack_pos = nreg + 1;
    s0 = succ_cnt;
    send(f3, "t3");
    for (int i = 0; i < 6; i++) h[5-i] = cap[i];
    chk("t3_head6", h[5:0], 6'b000001);
    chk("t3_stuff2", cap[11], 1);
    chk("t3_stuff3", cap[17], 1);
    chk("t3_len", last_len, 53);
    cmp_stream("t3_stream");
    chk("t3_success", succ_cnt - s0, 1);

    build(f2);
    ack_pos = nreg + 1;
    ack_val = 1;
    s0 = succ_cnt;
    a0 = ack_cnt;
    send(f2, "t4");
    chk("t4_ack_err", ack_cnt - a0, 1);
    chk("t4_no_success", succ_cnt - s0, 0);
    chk("t4_idle", {tx_active, tx_bit}, 2'b01);
    chk("t4_len", last_len, nreg + 2);
    ack_val = 0;

    build(f5);
    ack_pos = nreg + 1;
    arb_en = 1;
    arb_pos = 3;
    s0 = succ_cnt;
    r0 = arb_cnt;
    send(f5, "t5");
`ifdef CAN_ARB_MONITOR_EN
    chk("t5_arb_lost", arb_cnt - r0, 1);
    chk("t5_no_success", succ_cnt - s0, 0);
    chk("t5_len", last_len, 4);
`else
    chk("t5_arb_lost", arb_cnt - r0, 0);
    chk("t5_success", succ_cnt - s0, 1);
    cmp_stream("t5_stream");
`endif
    chk("t5_idle", {tx_active, tx_bit}, 2'b01);
    arb_en = 0;

    build(f6);
    ack_pos = nreg + 1;
    s0 = succ_cnt;
    send(f6, "t6");
    for (int i = 0; i < 19; i++) h[18-i] = cap[i];
    chk("t6_head19", h[18:0], 19'h2AA8F);
    chk("t6_success", succ_cnt - s0, 1);
    chk("t6_len", last_len, nex);
    cmp_stream("t6_stream");

    tx_frame = f6;
    frame_gen_intl = 1;
    to = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (fpos >= 30) begin
        to = 0;
        break;
      end
    end
    chk("t6r_timeout", to, 0);
    frame_gen_intl = 0;
    #2;
    g_rst = 0;
    #1;
    chk("t6r_tx_bit", tx_bit, 1);
    chk("t6r_active", tx_active, 0);
    repeat (2) @(negedge clk);
    g_rst = 1;
    @(negedge clk);

    build(f3);
    ack_pos = nreg + 1;
    s0 = succ_cnt;
    send(f3, "t7");
    chk("t7_success", succ_cnt - s0, 1);
    chk("t7_len", last_len, 53);
    cmp_stream("t7_stream");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/can_frame_gen.md
# can_frame_gen

Serializes one loaded CAN 2.0A transmit buffer into a bit-stuffed, CRC-protected standard data or remote frame. Sits directly downstream of the transmit buffer. Starts when `frame_gen_intl` asserts, snapshots the ten buffer bytes and drives `tx_bit` one bit per `bit_tick`. Reports completion, missing acknowledge or lost arbitration back to the buffer/host.

## Interface
- `MAX_DATA_BYTES`, default 8: cap on data bytes sent. Any DLC above this sends this many.
- `clk` in 1: system clock.
- `g_rst` in 1: asynchronous, active-low reset.
- `bit_tick` in 1: one-cycle pulse marking the end of the current bit time, from bit-timing logic.
- `frame_gen_intl` in 1: buffer loaded and frame ready; level, sampled in IDLE.
- `tx_frame` in 80: byte k at [8k+7:8k].
  - Byte0 = ID[10:3].
  - Byte1 = {ID[2:0], RTR, DLC[3:0]}.
  - Bytes 2..9 = data 0..7.
- `rx_bit` in 1: bus level readback; 0 = dominant.
- `tx_bit` out 1: bus drive; reset value 1 (recessive).
- `tx_active` out 1: high from SOF through last IFS bit; reset value 0.
- `tx_success` out 1: one-cycle pulse; reset value 0.
- `ack_err` out 1: one-cycle pulse; reset value 0.
- `arb_lost` out 1: one-cycle pulse; reset value 0.

## Operation
- **States:** IDLE, SOF, ARB (11 ID bits + RTR), CTRL (IDE=0, r0=0, DLC 4 bits), DATA, CRC (15 bits), CRC_DEL, ACK_SLOT, ACK_DEL, EOF (7 bits), IFS (3 bits).
- **IDLE:** when `frame_gen_intl`=1, latch `tx_frame` into an internal shadow register, clear the CRC, and go to SOF.
  - Later changes to `tx_frame` have no effect on the frame in progress.
- **Data byte count:**
  - RTR=1: 0.
  - RTR=0: min(DLC, `MAX_DATA_BYTES`).
  - The DLC field is always transmitted exactly as loaded (e.g. 0xF).
- **Bit order:** data bytes are sent MSB first, byte 2 first.
- **CRC:** CRC-15, polynomial 0x4599, initial value 0.
  - Computed over the unstuffed bits from SOF through the last data bit.
  - The CRC field is sent MSB first.
- **Bit stuffing:** active from SOF through the last CRC bit.
  - After 5 consecutive equal bits (stuff bits included in the count), insert one complement bit.
  - The field counter does not advance on a stuff bit.
  - The CRC does not include stuff bits.
  - No stuffing from CRC_DEL onward.
- **Fixed recessive bits (tx_bit=1):** CRC_DEL, ACK_SLOT, ACK_DEL, EOF and IFS.
- **ACK check:** at the `bit_tick` ending ACK_SLOT, if `rx_bit`=1:
  - pulse `ack_err`;
  - go to IDLE with tx_bit=1;
  - no `tx_success`.
- **Success:** at the `bit_tick` ending the 7th EOF bit, pulse `tx_success`, then run IFS.
  - IFS: 3 recessive bits, then IDLE.
  - `frame_gen_intl` still high on return to IDLE starts a new frame (upstream deasserts it on `tx_success`).
- **Arbitration:** see Configuration.
- **Reset mid-frame:** immediate return to the reset values; the shadow register and CRC are cleared.

## Timing
- **Bit boundaries:** all bit changes occur at `bit_tick`.
  - On a `bit_tick` cycle, the block evaluates `rx_bit` against the current `tx_bit`, then registers the next bit.
  - The next bit is visible on the following clock.
- **Start latency:** start in IDLE → SOF (tx_bit=0, tx_active=1) is driven from the first `bit_tick` after the latch cycle.
- **Frame length:** an unstuffed frame with N data bytes lasts 44+8N+3 bit times including IFS.
- **Without bit_tick:** no state advances when `bit_tick` is low.
- **Pulse timing:** `tx_success`, `ack_err` and `arb_lost` assert in the cycle following the deciding `bit_tick`, for exactly one clock.

## Configuration
- **`CAN_ARB_MONITOR_EN` defined:**
  - During ARB, if tx_bit=1 and `rx_bit`=0 at `bit_tick`, pulse `arb_lost` and go to IDLE.
  - tx_bit is 1 from the next cycle.
  - No `tx_success`.
  - Stuff bits in ARB are monitored too.
- **Undefined:**
  - `arb_lost` is tied to 0.
  - `rx_bit` is used only in ACK_SLOT.

## Structure
- **Package `can_pkg`:**
  - State enum.
  - CRC15 polynomial constant.
  - Field lengths (ID 11, DLC 4, CRC 15, EOF 7, IFS 3).
  - Stuff limit 5.
  - Byte-index constants for the buffer layout.
- **Sub-module `can_crc15`:** serial CRC-15.
  - Inputs: clk, g_rst, clear, enable, bit.
  - Output: 15-bit crc.

## Test plan
1. Reset held low → tx_bit=1, tx_active=0, all pulses 0; release with `frame_gen_intl`=0 → stays idle over 20 bit_ticks.
2. ID 0x123, RTR 0, DLC 1, data 0xAA (byte0=0x24, byte1=0x61, byte2=0xAA), rx_bit=tx_bit except ACK_SLOT forced 0 → stuffed stream and CRC match a reference model, one `tx_success`, tx_active low after 3 IFS bits.
3. ID 0x000, RTR 0, DLC 0 → stuff bit 1 inserted as the 6th transmitted bit (after SOF + ID[10:7]), further stuff bits every 5 zeros.
4. Same as 2 but rx_bit=1 in ACK_SLOT → one `ack_err` pulse, no `tx_success`, tx_bit=1, state IDLE.
5. With `CAN_ARB_MONITOR_EN`, ID 0x7FF, force rx_bit=0 during the 3rd ID bit → `arb_lost` pulse, tx_bit=1 next cycle, no `tx_success`.
6. DLC 0xF, RTR 0 → DLC field 1111, exactly 8 data bytes; g_rst asserted during DATA → tx_bit=1, tx_active=0 immediately.
